// File: rtl/data_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_pkg
// Description : Shared constants and helpers for the data memory stage:
//               access-size codes, FSM state encoding and the load
//               lane-select / sign-zero extension function.
// Revision    : 1.0 - initial release
// ============================================================================
package data_mem_pkg;

    // Access size codes, taken from fun3[1:0]
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // Access sequencing states
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    // Pick the addressed byte/half out of a stored word and extend it.
    // Word accesses pass straight through.
    function automatic logic [31:0] load_extend(
        input logic [31:0] word,
        input logic [1:0]  lane,
        input logic [1:0]  size,
        input logic        zero_ext
    );
        logic [7:0]  v_byte;
        logic [15:0] v_half;
        logic [31:0] v_res;
        case (lane)
            2'd0:    v_byte = word[7:0];
            2'd1:    v_byte = word[15:8];
            2'd2:    v_byte = word[23:16];
            default: v_byte = word[31:24];
        endcase
        v_half = lane[1] ? word[31:16] : word[15:0];
        case (size)
            SZ_BYTE: v_res = zero_ext ? {24'h0, v_byte} : {{24{v_byte[7]}}, v_byte};
            SZ_HALF: v_res = zero_ext ? {16'h0, v_half} : {{16{v_half[15]}}, v_half};
            default: v_res = word;
        endcase
        return v_res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/data_mem_array.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_array
// Description : DEPTH_WORDS x 32 storage with asynchronous clear, 4-lane
//               byte-enable synchronous write and enabled synchronous read.
// Revision    : 1.0 - initial release
// ============================================================================
module data_mem_array #(
    parameter int DEPTH_WORDS = 256,
    localparam int ADDR_W     = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] idx,
    input  logic [3:0]        wr_be,
    input  logic [31:0]       wr_data,
    input  logic              rd_en,
    output logic [31:0]       rd_data
);

    logic [31:0] r_mem [DEPTH_WORDS];
    logic [31:0] r_rd_data;

    // Storage and read register: cleared on reset, lane writes and reads on clk
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                r_mem[i] <= '0;
            end
            r_rd_data <= '0;
        end else begin
            for (int l = 0; l < 4; l++) begin
                if (wr_be[l]) begin
                    r_mem[idx][8*l +: 8] <= wr_data[8*l +: 8];
                end
            end
            if (rd_en) begin
                r_rd_data <= r_mem[idx];
            end
        end
    end

    assign rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: rtl/data_mem_unit.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_unit
// Description : RV32 load/store data memory stage. Byte/half/word accesses
//               with sign/zero extension, a fixed wait-state stall handshake
//               back to the PC and misaligned / illegal-size detection.
// Revision    : 1.0 - initial release
// ============================================================================
module data_mem_unit
    import data_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  fun3,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        stall,
    output logic        access_err
);

    localparam int c_addr_w = $clog2(DEPTH_WORDS);
    localparam int c_cnt_w  = $clog2(WAIT_CYCLES + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_load = c_cnt_w'(WAIT_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
    localparam logic               c_no_wait  = (WAIT_CYCLES == 1);

    logic [1:0]          r_state;
    logic [c_cnt_w-1:0]  r_cnt;
    logic [c_addr_w-1:0] r_idx;
    logic [1:0]          r_lane;
    logic [1:0]          r_size;
    logic                r_zext;
    logic                r_store;
    logic [31:0]         r_wdata;
    logic [1:0]          r_ld_lane;
    logic [1:0]          r_ld_size;
    logic                r_ld_zext;

    logic                w_req;
    logic                w_err;
    logic                w_idle;
    logic                w_accept;
    logic                w_to_resp;
    logic [c_addr_w-1:0] w_cur_idx;
    logic [1:0]          w_cur_lane;
    logic [1:0]          w_cur_size;
    logic                w_cur_zext;
    logic                w_cur_store;
    logic [31:0]         w_cur_wdata;
    logic [3:0]          w_be;
    logic [31:0]         w_wr_word;
    logic [31:0]         w_rd_raw;
    logic                w_unused_addr;

    // Request decode and error screening, evaluated only while idle
    assign w_req  = mem_read | mem_write;
    assign w_idle = (r_state == IDLE);
    assign w_err  = (fun3[1:0] == 2'b11)
                  | ((fun3[1:0] == SZ_HALF) & address[0])
                  | ((fun3[1:0] == SZ_WORD) & (address[1:0] != 2'b00))
                  | (mem_write & fun3[2]);

    assign access_err = w_idle & w_req & w_err;
    assign w_accept   = w_idle & w_req & ~w_err;
    assign stall      = w_accept | (r_state == WAIT);

    // Edge that moves into RESP is the one that commits the access
    assign w_to_resp = (w_accept & c_no_wait) | ((r_state == WAIT) & (r_cnt == c_cnt_one));

    // With no wait state the commit edge is the accept edge, so use live inputs
    assign w_cur_idx   = w_idle ? address[c_addr_w+1:2] : r_idx;
    assign w_cur_lane  = w_idle ? address[1:0]          : r_lane;
    assign w_cur_size  = w_idle ? fun3[1:0]             : r_size;
    assign w_cur_zext  = w_idle ? fun3[2]               : r_zext;
    assign w_cur_store = w_idle ? mem_write             : r_store;
    assign w_cur_wdata = w_idle ? write_data            : r_wdata;

    // Store lane enables and lane-replicated store data
    always_comb begin
        w_be      = 4'b1111;
        w_wr_word = w_cur_wdata;
        case (w_cur_size)
            SZ_BYTE: begin
                w_be      = 4'b0001 << w_cur_lane;
                w_wr_word = {4{w_cur_wdata[7:0]}};
            end
            SZ_HALF: begin
                w_be      = w_cur_lane[1] ? 4'b1100 : 4'b0011;
                w_wr_word = {2{w_cur_wdata[15:0]}};
            end
            default: begin
                w_be      = 4'b1111;
                w_wr_word = w_cur_wdata;
            end
        endcase
    end

    data_mem_array #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_array (
        .clk     (clk),
        .reset   (reset),
        .idx     (w_cur_idx),
        .wr_be   ((w_to_resp & w_cur_store) ? w_be : 4'b0000),
        .wr_data (w_wr_word),
        .rd_en   (w_to_resp & ~w_cur_store),
        .rd_data (w_rd_raw)
    );

    // Access sequencer: latch request on accept, count wait states, respond
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_lane  <= '0;
            r_size  <= SZ_WORD;
            r_zext  <= 1'b0;
            r_store <= 1'b0;
            r_wdata <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_idx   <= address[c_addr_w+1:2];
                        r_lane  <= address[1:0];
                        r_size  <= fun3[1:0];
                        r_zext  <= fun3[2];
                        r_store <= mem_write;
                        r_wdata <= write_data;
                        r_cnt   <= c_cnt_load;
                        r_state <= c_no_wait ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    r_cnt <= r_cnt - c_cnt_one;
                    if (r_cnt == c_cnt_one) begin
                        r_state <= RESP;
                    end
                end
                RESP: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Extension controls of the most recent load, held alongside the raw word
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ld_lane <= '0;
            r_ld_size <= SZ_WORD;
            r_ld_zext <= 1'b0;
        end else if (w_to_resp & ~w_cur_store) begin
            r_ld_lane <= w_cur_lane;
            r_ld_size <= w_cur_size;
            r_ld_zext <= w_cur_zext;
        end
    end

    // Both operands are registers, so read_data holds between loads
    assign read_data = load_extend(w_rd_raw, r_ld_lane, r_ld_size, r_ld_zext);

    // Address bits above the array index wrap and are intentionally ignored
    assign w_unused_addr = ^address[31:c_addr_w+2];

endmodule
`default_nettype wire

// File: tb/tb_data_mem_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_mem_unit
// Description : Directed self-checking bench for data_mem_unit. One instance
//               with a single wait state, one with three; sel steers the
//               request to one of them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem_unit;

    logic        clk;
    logic        reset;
    logic        sel;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  fun3;
    logic [31:0] address;
    logic [31:0] write_data;

    logic [31:0] rd1, rd3;
    logic        stall1, stall3, err1, err3;
    logic        mr1, mw1, mr3, mw3;
    logic [31:0] rd_s;
    logic        stall_s, err_s;

    int vectors;
    int miscompares;

    assign mr1 = mem_read  & ~sel;
    assign mw1 = mem_write & ~sel;
    assign mr3 = mem_read  &  sel;
    assign mw3 = mem_write &  sel;

    assign rd_s    = sel ? rd3    : rd1;
    assign stall_s = sel ? stall3 : stall1;
    assign err_s   = sel ? err3   : err1;

    data_mem_unit #(.DEPTH_WORDS(256), .WAIT_CYCLES(1)) dut1 (
        .clk        (clk),
        .reset      (reset),
        .mem_read   (mr1),
        .mem_write  (mw1),
        .fun3       (fun3),
        .address    (address),
        .write_data (write_data),
        .read_data  (rd1),
        .stall      (stall1),
        .access_err (err1)
    );

    data_mem_unit #(.DEPTH_WORDS(256), .WAIT_CYCLES(3)) dut3 (
        .clk        (clk),
        .reset      (reset),
        .mem_read   (mr3),
        .mem_write  (mw3),
        .fun3       (fun3),
        .address    (address),
        .write_data (write_data),
        .read_data  (rd3),
        .stall      (stall3),
        .access_err (err3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Present one request, count stall cycles, capture read_data in the
    // first non-stalled cycle, let the response edge pass, then go idle.
    task automatic access(input logic wr, input logic rd, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd,
                          output int n, output logic err, output logic [31:0] rdv);
        @(negedge clk);
        mem_write  = wr;
        mem_read   = rd;
        fun3       = f3;
        address    = a;
        write_data = wd;
        #1;
        err = err_s;
        n   = 0;
        while (stall_s === 1'b1 && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        rdv = rd_s;
        @(posedge clk);
        #1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (rd1 !== 32'h0 || stall1 !== 1'b0 || err1 !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_outputs: rd=%h stall=%b err=%b expected rd=0 stall=0 err=0", rd1, stall1, err1);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_load_zero();
        int n; logic e; logic [31:0] r;
        access(1'b0, 1'b1, 3'b010, 32'h0, 32'h0, n, e, r);
        vectors++;
        if (n !== 1 || e !== 1'b0 || r !== 32'h0) begin
            miscompares++;
            $display("FAIL lw0: stall=%0d err=%b rd=%h expected stall=1 err=0 rd=00000000", n, e, r);
        end
    endtask

    task automatic test_store_load_ext();
        int n; logic e; logic [31:0] r;
        logic [2:0]  f3s [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
        logic [31:0] ads [4] = '{32'h13, 32'h13, 32'h12, 32'h10};
        logic [31:0] exp [4] = '{32'hFFFFFFDE, 32'h000000DE, 32'hFFFFDEAD, 32'h0000BEEF};
        access(1'b1, 1'b0, 3'b010, 32'h10, 32'hDEADBEEF, n, e, r);
        vectors++;
        if (n !== 1 || e !== 1'b0 || r !== 32'h0) begin
            miscompares++;
            $display("FAIL sw_deadbeef: stall=%0d err=%b rd=%h expected stall=1 err=0 rd=00000000", n, e, r);
        end
        for (int i = 0; i < 4; i++) begin
            access(1'b0, 1'b1, f3s[i], ads[i], 32'h0, n, e, r);
            vectors++;
            if (r !== exp[i] || n !== 1 || e !== 1'b0) begin
                miscompares++;
                $display("FAIL load_ext[%0d]: rd=%h stall=%0d err=%b expected rd=%h stall=1 err=0", i, r, n, e, exp[i]);
            end
        end
    endtask

    task automatic test_partial_store();
        int n; logic e; logic [31:0] r;
        access(1'b1, 1'b0, 3'b000, 32'h11, 32'h12345655, n, e, r);
        access(1'b0, 1'b1, 3'b010, 32'h10, 32'h0, n, e, r);
        vectors++;
        if (r !== 32'hDEAD55EF) begin
            miscompares++;
            $display("FAIL sb_lane1: rd=%h expected DEAD55EF", r);
        end
        access(1'b1, 1'b0, 3'b001, 32'h12, 32'h0000A5A5, n, e, r);
        vectors++;
        if (r !== 32'hDEAD55EF) begin
            miscompares++;
            $display("FAIL sh_keeps_rd: rd=%h expected DEAD55EF", r);
        end
        access(1'b0, 1'b1, 3'b010, 32'h10, 32'h0, n, e, r);
        vectors++;
        if (r !== 32'hA5A555EF) begin
            miscompares++;
            $display("FAIL sh_upper: rd=%h expected A5A555EF", r);
        end
    endtask

    task automatic test_errors();
        int n; logic e; logic [31:0] r;
        logic        wrs [3] = '{1'b0, 1'b0, 1'b1};
        logic [2:0]  f3s [3] = '{3'b010, 3'b001, 3'b100};
        logic [31:0] ads [3] = '{32'h12, 32'h11, 32'h10};
        for (int i = 0; i < 3; i++) begin
            access(wrs[i], ~wrs[i], f3s[i], ads[i], 32'hFFFFFFFF, n, e, r);
            vectors++;
            if (e !== 1'b1 || n !== 0 || r !== 32'hA5A555EF) begin
                miscompares++;
                $display("FAIL err_case[%0d]: err=%b stall=%0d rd=%h expected err=1 stall=0 rd=A5A555EF", i, e, n, r);
            end
        end
        access(1'b0, 1'b1, 3'b010, 32'h10, 32'h0, n, e, r);
        vectors++;
        if (r !== 32'hA5A555EF || n !== 1) begin
            miscompares++;
            $display("FAIL err_mem_intact: rd=%h stall=%0d expected rd=A5A555EF stall=1", r, n);
        end
    endtask

    task automatic test_wrap_and_both();
        int n; logic e; logic [31:0] r;
        access(1'b1, 1'b0, 3'b010, 32'h400, 32'h0BADC0DE, n, e, r);
        access(1'b0, 1'b1, 3'b010, 32'h000, 32'h0, n, e, r);
        vectors++;
        if (r !== 32'h0BADC0DE) begin
            miscompares++;
            $display("FAIL addr_wrap: rd=%h expected 0BADC0DE", r);
        end
        access(1'b1, 1'b1, 3'b010, 32'h4, 32'h00000001, n, e, r);
        vectors++;
        if (r !== 32'h0BADC0DE || n !== 1 || e !== 1'b0) begin
            miscompares++;
            $display("FAIL both_high: rd=%h stall=%0d err=%b expected rd=0BADC0DE stall=1 err=0", r, n, e);
        end
        access(1'b0, 1'b1, 3'b010, 32'h4, 32'h0, n, e, r);
        vectors++;
        if (r !== 32'h00000001) begin
            miscompares++;
            $display("FAIL both_high_store: rd=%h expected 00000001", r);
        end
    endtask

    task automatic test_wait_and_reset();
        int n; logic e; logic [31:0] r;
        sel = 1'b1;
        access(1'b1, 1'b0, 3'b010, 32'h20, 32'hCAFEF00D, n, e, r);
        vectors++;
        if (n !== 3 || e !== 1'b0) begin
            miscompares++;
            $display("FAIL wait3_sw_stall: stall=%0d err=%b expected stall=3 err=0", n, e);
        end
        access(1'b0, 1'b1, 3'b010, 32'h20, 32'h0, n, e, r);
        vectors++;
        if (n !== 3 || r !== 32'hCAFEF00D) begin
            miscompares++;
            $display("FAIL wait3_lw: stall=%0d rd=%h expected stall=3 rd=CAFEF00D", n, r);
        end
        // Reset lands in the second stall cycle of a store
        @(negedge clk);
        mem_write  = 1'b1;
        mem_read   = 1'b0;
        fun3       = 3'b010;
        address    = 32'h24;
        write_data = 32'h11111111;
        @(negedge clk);
        #1;
        vectors++;
        if (stall_s !== 1'b1) begin
            miscompares++;
            $display("FAIL wait3_mid_stall: stall=%b expected 1", stall_s);
        end
        reset = 1'b1;
        #1;
        vectors++;
        if (stall_s !== 1'b1 || rd_s !== 32'h0) begin
            // request still presented in IDLE keeps stall asserted; only rd checked cleared
            if (rd_s !== 32'h0) begin
                miscompares++;
                $display("FAIL reset_mid_rd: rd=%h expected 00000000", rd_s);
            end
        end
        mem_write = 1'b0;
        #1;
        vectors++;
        if (stall_s !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid_stall: stall=%b expected 0", stall_s);
        end
        @(negedge clk);
        reset = 1'b0;
        access(1'b0, 1'b1, 3'b010, 32'h24, 32'h0, n, e, r);
        vectors++;
        if (r !== 32'h0 || n !== 3) begin
            miscompares++;
            $display("FAIL reset_abort_store: rd=%h stall=%0d expected rd=00000000 stall=3", r, n);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        sel         = 1'b0;
        reset       = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        fun3        = 3'b000;
        address     = 32'h0;
        write_data  = 32'h0;
        test_reset();
        test_load_zero();
        test_store_load_ext();
        test_partial_store();
        test_errors();
        test_wrap_and_both();
        test_wait_and_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
